audio_source_fader: RTL and testbench
=====================================

Name: audio_source_fader

Overview:
- Controls the audio source selection between the synth sample stream and the live codec ADC sample stream.
- Replaces a hard, unsynchronised switch-driven mux with a debounced request and a per-frame gain ramp: fade out, swap source, fade in.
- Sits in the CLOCK_50 domain between the parallel sample producers and the I2S serializer feeding the codec DAC.
- All updates align to the codec frame strobe, so source changes produce no clicks.

Parameters:
- SAMPLE_W, 16, signed sample width per channel.
- FADE_STEP, 8, gain change per frame; 256/8 gives a 32-frame ramp.
- DEBOUNCE_CYC, 500000, CLOCK_50 cycles the synchronised select must stay stable before it is accepted (10 ms).

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- RST_N  in  1  asynchronous active-low reset.
- SEL_RAW  in  1  raw slide-switch source request; 1 = synth, 0 = live. Asynchronous.
- FRAME_STB  in  1  one-cycle pulse per stereo frame, already in the CLOCK_50 domain.
- SYNTH_L, SYNTH_R  in  SAMPLE_W  signed synth samples, valid whenever FRAME_STB is high.
- LIVE_L, LIVE_R  in  SAMPLE_W  signed ADC samples, valid whenever FRAME_STB is high.
- OUT_L, OUT_R  out  SAMPLE_W  signed scaled output samples.
- OUT_VALID  out  1  one-cycle pulse; OUT_L/OUT_R are updated in the same cycle.
- ACTIVE_SRC  out  1  source currently routed to the output.
- BUSY  out  1  high in any state other than PLAY.
- GAIN  out  9  current gain, 0..256; 256 = unity.

Behaviour:
- Reset (async assert, sync release): state = PLAY, ACTIVE_SRC = 0, GAIN = 256, debounced select = 0, debounce counter = 0, OUT_L = OUT_R = 0, OUT_VALID = 0, BUSY = 0.
- Select debounce:
  - SEL_RAW passes through a 2-flop synchroniser.
  - The counter clears whenever the synchronised value differs from the candidate; the candidate then updates.
  - The debounced select (sel_db) takes the candidate once the counter reaches DEBOUNCE_CYC-1 with the candidate unchanged.
- Datapath:
  - On a FRAME_STB cycle, select the source by ACTIVE_SRC and form product = sample * {1'b0, GAIN} as a 26-bit signed value.
  - OUT_x is registered from product[23:8] (arithmetic shift; truncation toward minus infinity).
  - OUT_VALID pulses in the next cycle (latency 1). OUT_x holds between strobes.
  - GAIN = 256 gives exact passthrough; GAIN = 0 gives exactly 0.
  - The datapath uses the GAIN value before that cycle's update.
- FSM (transitions and gain updates occur only on a FRAME_STB cycle, except SWAP):
  - PLAY: if sel_db != ACTIVE_SRC, go to FADE_OUT. GAIN stays 256.
  - FADE_OUT: each strobe sets GAIN = max(GAIN - FADE_STEP, 0).
    - If the new GAIN is 0, go to SWAP.
    - If sel_db == ACTIVE_SRC (request reverted), go to FADE_IN from the current gain without a swap.
  - SWAP: exactly one cycle, independent of FRAME_STB. ACTIVE_SRC <= sel_db, then go to FADE_IN.
  - FADE_IN: each strobe sets GAIN = min(GAIN + FADE_STEP, 256).
    - If the new GAIN is 256, go to PLAY.
    - If sel_db != ACTIVE_SRC (new request), go to FADE_OUT from the current gain.
- Saturation: when FADE_STEP does not divide 256, the last step clamps to exactly 0 or 256. GAIN never wraps.
- FRAME_STB coinciding with SWAP: the sample is output with GAIN = 0, which is silent. ACTIVE_SRC changes at the end of that cycle.
- A reset mid-fade returns immediately to the reset values; no ramp on reset release.
- sel_db changing while in SWAP is handled by the next FADE_IN check.

Decomposition:
- Package audio_ctrl_pkg:
  - state enum (PLAY, FADE_OUT, SWAP, FADE_IN);
  - GAIN_UNITY = 256;
  - SRC_LIVE = 0, SRC_SYNTH = 1.
- Sub-module switch_debounce: synchroniser plus stability counter, parameterised by DEBOUNCE_CYC. It is reused later for KEY inputs.

Test Plan (use DEBOUNCE_CYC = 16 in simulation):
- Reset with SEL_RAW = 0: LIVE_L = 16'h1234 with a strobe gives OUT_L = 16'h1234 with OUT_VALID one cycle later; GAIN = 256, BUSY = 0.
- SEL_RAW 0->1 held: sel_db rises after 2 + 16 cycles. Gain then steps 248, 240, … 0 over 32 strobes. SWAP sets ACTIVE_SRC = 1. Gain rises over 32 strobes back to 256, then PLAY.
- SEL_RAW pulse of 10 cycles: sel_db, GAIN and ACTIVE_SRC remain unchanged.
- Revert mid-fade: at GAIN = 128 in FADE_OUT, return SEL_RAW to 0. FADE_IN climbs from 128 to 256 in 16 strobes; ACTIVE_SRC never changes.
- FADE_STEP = 24: gain sequence 232 … 16, 0 (clamped), then 24 … 240, 256 (clamped). LIVE_L = -1 at gain 128 gives OUT_L = -1; -32768 at gain 256 gives -32768.
- RST_N asserted during FADE_IN at GAIN = 64: all outputs return to reset values asynchronously, with no OUT_VALID on release.

Source files
------------

// File: rtl/audio_ctrl_pkg.sv
// Shared types and constants for the audio source fader and related control blocks.
// Gain is a 9-bit unsigned fraction of 256, so 256 means unity.
package audio_ctrl_pkg;

  typedef enum logic [1:0] {
    PLAY     = 2'd0,
    FADE_OUT = 2'd1,
    SWAP     = 2'd2,
    FADE_IN  = 2'd3
  } fade_state_e;

  localparam int              GAIN_W     = 9;
  localparam logic [GAIN_W-1:0] GAIN_UNITY = 9'd256;

  localparam logic SRC_LIVE  = 1'b0;
  localparam logic SRC_SYNTH = 1'b1;

  // Saturating gain steps; the last step of a ramp lands exactly on 0 or unity.
  function automatic logic [GAIN_W-1:0] gain_down(input logic [GAIN_W-1:0] g,
                                                  input int step);
    int v;
    v = int'(g) - step;
    return (v <= 0) ? '0 : GAIN_W'(v);
  endfunction

  function automatic logic [GAIN_W-1:0] gain_up(input logic [GAIN_W-1:0] g,
                                                input int step);
    int v;
    v = int'(g) + step;
    return (v >= int'(GAIN_UNITY)) ? GAIN_UNITY : GAIN_W'(v);
  endfunction

endpackage

// File: rtl/switch_debounce.sv
// Two-flop synchroniser plus stability counter for a mechanical switch or key.
// The output only follows the input after it has held one value for DEBOUNCE_CYC clocks.
module switch_debounce #(
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_raw,
  output logic sw_db
);

  localparam int                CNT_W    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [1:0]       sync_q;
  logic             cand_q;
  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cand_q <= 1'b0;
      cnt_q  <= '0;
      sw_db  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], sw_raw};
      if (sync_q[1] != cand_q) begin
        cand_q <= sync_q[1];
        cnt_q  <= '0;
      end else if (cnt_q == CNT_LAST) begin
        sw_db <= cand_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/audio_source_fader.sv
// Click-free switch between synth and live codec samples: fade out, swap source, fade in,
// with every gain change and output update aligned to the codec frame strobe.
module audio_source_fader
  import audio_ctrl_pkg::*;
#(
  parameter int SAMPLE_W     = 16,
  parameter int FADE_STEP    = 8,
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic                       CLOCK_50,
  input  logic                       RST_N,
  input  logic                       SEL_RAW,
  input  logic                       FRAME_STB,
  input  logic signed [SAMPLE_W-1:0] SYNTH_L,
  input  logic signed [SAMPLE_W-1:0] SYNTH_R,
  input  logic signed [SAMPLE_W-1:0] LIVE_L,
  input  logic signed [SAMPLE_W-1:0] LIVE_R,
  output logic signed [SAMPLE_W-1:0] OUT_L,
  output logic signed [SAMPLE_W-1:0] OUT_R,
  output logic                       OUT_VALID,
  output logic                       ACTIVE_SRC,
  output logic                       BUSY,
  output logic [GAIN_W-1:0]          GAIN
);

  localparam int PROD_W = SAMPLE_W + GAIN_W + 1;

  // Sample * gain in signed arithmetic; the >>> 8 floors toward minus infinity.
  function automatic logic signed [SAMPLE_W-1:0] apply_gain(
    input logic signed [SAMPLE_W-1:0] s,
    input logic        [GAIN_W-1:0]   g
  );
    logic signed [PROD_W-1:0] p;
    p = PROD_W'(s) * PROD_W'($signed({1'b0, g}));
    return SAMPLE_W'(p >>> 8);
  endfunction

  // NOTE: reset asserts asynchronously but releases on a clock edge, so no flop sees
  // a reset release racing the clock.
  logic [1:0] rst_sync_q;
  logic       rst_n_i;

  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n_i = rst_sync_q[1];

  logic sel_db;

  switch_debounce #(
    .DEBOUNCE_CYC (DEBOUNCE_CYC)
  ) u_sel_debounce (
    .clk    (CLOCK_50),
    .rst_n  (rst_n_i),
    .sw_raw (SEL_RAW),
    .sw_db  (sel_db)
  );

  fade_state_e       state_q, state_d;
  logic [GAIN_W-1:0] gain_q, gain_d;
  logic              active_src_q, active_src_d;
  logic [GAIN_W-1:0] gain_dn, gain_inc;

  assign gain_dn  = gain_down(gain_q, FADE_STEP);
  assign gain_inc = gain_up(gain_q, FADE_STEP);

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    gain_d       = gain_q;
    active_src_d = active_src_q;
    unique case (state_q)
      PLAY: begin
        if (FRAME_STB && (sel_db != active_src_q)) state_d = FADE_OUT;
      end
      FADE_OUT: begin
        if (FRAME_STB) begin
          gain_d = gain_dn;
          if (gain_dn == '0)                  state_d = SWAP;
          else if (sel_db == active_src_q)    state_d = FADE_IN;
        end
      end
      SWAP: begin
        // Single cycle regardless of strobe; a changed request is caught in FADE_IN.
        active_src_d = sel_db;
        state_d      = FADE_IN;
      end
      FADE_IN: begin
        if (FRAME_STB) begin
          gain_d = gain_inc;
          if (gain_inc == GAIN_UNITY)         state_d = PLAY;
          else if (sel_db != active_src_q)    state_d = FADE_OUT;
        end
      end
      default: state_d = PLAY;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= PLAY;
      gain_q       <= GAIN_UNITY;
      active_src_q <= SRC_LIVE;
    end else begin
      state_q      <= state_d;
      gain_q       <= gain_d;
      active_src_q <= active_src_d;
    end
  end

  logic signed [SAMPLE_W-1:0] smp_l, smp_r;

  assign smp_l = (active_src_q == SRC_SYNTH) ? SYNTH_L : LIVE_L;
  assign smp_r = (active_src_q == SRC_SYNTH) ? SYNTH_R : LIVE_R;

  // Scaling uses the pre-update gain, so a strobe during SWAP is output at gain 0.
  always_ff @(posedge CLOCK_50 or negedge rst_n_i) begin
    if (!rst_n_i) begin
      OUT_L     <= '0;
      OUT_R     <= '0;
      OUT_VALID <= 1'b0;
    end else begin
      OUT_VALID <= FRAME_STB;
      if (FRAME_STB) begin
        OUT_L <= apply_gain(smp_l, gain_q);
        OUT_R <= apply_gain(smp_r, gain_q);
      end
    end
  end

  assign ACTIVE_SRC = active_src_q;
  assign BUSY       = (state_q != PLAY);
  assign GAIN       = gain_q;

endmodule

// File: tb/tb_audio_source_fader.sv
// Bench for audio_source_fader: two instances (FADE_STEP 8 and 24) on shared stimulus,
// a frame-level reference model feeding a scoreboard, plus table and hand-written sequences.
module tb_audio_source_fader;
  import audio_ctrl_pkg::*;

  localparam int DCYC = 16;
  localparam int STEP [2] = '{8, 24};

  typedef struct {
    logic signed [15:0] l;
    logic signed [15:0] r;
    int                 due;
  } sb_t;

  typedef struct {
    logic signed [15:0] ll, lr, sl, sr;
    logic signed [15:0] el, er;
  } vec_t;

  logic CLOCK_50 = 1'b0;
  logic RST_N    = 1'b0;
  logic SEL_RAW  = 1'b0;
  logic FRAME_STB = 1'b0;
  logic signed [15:0] SYNTH_L = '0, SYNTH_R = '0, LIVE_L = '0, LIVE_R = '0;

  logic signed [15:0] out_l [2];
  logic signed [15:0] out_r [2];
  logic               out_valid [2];
  logic               active [2];
  logic               busy [2];
  logic [8:0]         gain [2];

  audio_source_fader #(.SAMPLE_W(16), .FADE_STEP(8), .DEBOUNCE_CYC(DCYC)) dut (
    .CLOCK_50 (CLOCK_50), .RST_N (RST_N), .SEL_RAW (SEL_RAW), .FRAME_STB (FRAME_STB),
    .SYNTH_L (SYNTH_L), .SYNTH_R (SYNTH_R), .LIVE_L (LIVE_L), .LIVE_R (LIVE_R),
    .OUT_L (out_l[0]), .OUT_R (out_r[0]), .OUT_VALID (out_valid[0]),
    .ACTIVE_SRC (active[0]), .BUSY (busy[0]), .GAIN (gain[0])
  );

  audio_source_fader #(.SAMPLE_W(16), .FADE_STEP(24), .DEBOUNCE_CYC(DCYC)) dut24 (
    .CLOCK_50 (CLOCK_50), .RST_N (RST_N), .SEL_RAW (SEL_RAW), .FRAME_STB (FRAME_STB),
    .SYNTH_L (SYNTH_L), .SYNTH_R (SYNTH_R), .LIVE_L (LIVE_L), .LIVE_R (LIVE_R),
    .OUT_L (out_l[1]), .OUT_R (out_r[1]), .OUT_VALID (out_valid[1]),
    .ACTIVE_SRC (active[1]), .BUSY (busy[1]), .GAIN (gain[1])
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_errors = 0;
  int cycle_cnt = 0;

  always @(posedge CLOCK_50) cycle_cnt++;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycle_cnt);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  fade_state_e m_state [2];
  int          m_gain [2];
  logic        m_active [2];
  int          m_zero_pe [2];
  logic        m_sel;
  sb_t         sbq [2][$];

  function automatic logic signed [15:0] scale(input logic signed [15:0] s, input int g);
    longint p;
    p = longint'(s) * longint'(g);
    return 16'(p >>> 8);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_state[i] = PLAY; m_gain[i] = 256; m_active[i] = 1'b0; m_zero_pe[i] = -10;
      sbq[i].delete();
    end
    m_sel = 1'b0;
  endtask

  task automatic model_swap(input int i);
    m_active[i] = m_sel;
    m_state[i]  = FADE_IN;
  endtask

  task automatic model_settle(input int i);
    if (m_state[i] == SWAP) model_swap(i);
  endtask

  task automatic model_frame(input int i, input int pe,
                             input logic signed [15:0] ll, lr, sl, sr, output sb_t e);
    if (m_state[i] == SWAP && pe != m_zero_pe[i] + 1) model_swap(i);
    e.l   = scale(m_active[i] ? sl : ll, m_gain[i]);
    e.r   = scale(m_active[i] ? sr : lr, m_gain[i]);
    e.due = pe;
    case (m_state[i])
      PLAY: if (m_sel != m_active[i]) m_state[i] = FADE_OUT;
      FADE_OUT: begin
        m_gain[i] = (m_gain[i] > STEP[i]) ? m_gain[i] - STEP[i] : 0;
        if (m_gain[i] == 0) begin m_state[i] = SWAP; m_zero_pe[i] = pe; end
        else if (m_sel == m_active[i]) m_state[i] = FADE_IN;
      end
      SWAP: model_swap(i);
      FADE_IN: begin
        m_gain[i] = (m_gain[i] + STEP[i] < 256) ? m_gain[i] + STEP[i] : 256;
        if (m_gain[i] == 256) m_state[i] = PLAY;
        else if (m_sel != m_active[i]) m_state[i] = FADE_OUT;
      end
      default: ;
    endcase
  endtask

  // ---------------- stimulus helpers (called at a falling edge) ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic send_frame(input logic signed [15:0] ll, lr, sl, sr);
    sb_t e;
    int  pe;
    pe = cycle_cnt + 1;
    LIVE_L = ll; LIVE_R = lr; SYNTH_L = sl; SYNTH_R = sr;
    FRAME_STB = 1'b1;
    for (int i = 0; i < 2; i++) begin
      model_frame(i, pe, ll, lr, sl, sr, e);
      sbq[i].push_back(e);
    end
    @(negedge CLOCK_50);
    FRAME_STB = 1'b0;
  endtask

  task automatic send_rand();
    send_frame(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
  endtask

  task automatic check_status(input int i);
    model_settle(i);
    check($sformatf("gain%0d", i),   gain[i],   m_gain[i]);
    check($sformatf("busy%0d", i),   busy[i],   (m_state[i] != PLAY) ? 1 : 0);
    check($sformatf("active%0d", i), active[i], m_active[i]);
  endtask

  task automatic strobe_chk();
    send_rand();
    idle(3);
    check_status(0);
    check_status(1);
  endtask

  function automatic int b_ramp(input int k);
    if (k <= 11) return (256 - 24 * k > 0) ? 256 - 24 * k : 0;
    return (24 * (k - 11) < 256) ? 24 * (k - 11) : 256;
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge CLOCK_50) begin : monitor
    sb_t e;
    if (RST_N) begin
      for (int i = 0; i < 2; i++) begin
        if (out_valid[i]) begin
          if (sbq[i].size() == 0) begin
            check($sformatf("unexpected_valid%0d", i), 1, 0);
          end else begin
            e = sbq[i].pop_front();
            check($sformatf("latency%0d", i), cycle_cnt, e.due);
            check($sformatf("out_l%0d", i), out_l[i], e.l);
            check($sformatf("out_r%0d", i), out_r[i], e.r);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #4000000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    vec_t vecs [6];
    int   vcount;
    int   n;

    vecs[0] = '{16'h1234, 16'h0042, 16'h7000, 16'hFFFB, 16'h1234, 16'h0042};
    vecs[1] = '{16'h7FFF, 16'h8000, 16'h0001, 16'h0001, 16'h7FFF, 16'h8000};
    vecs[2] = '{16'hFFFF, 16'h0000, 16'h5555, 16'hAAAA, 16'hFFFF, 16'h0000};
    vecs[3] = '{16'h8000, 16'h7FFF, 16'h0000, 16'h0000, 16'h8000, 16'h7FFF};
    vecs[4] = '{16'h0001, 16'hFFFE, 16'h1111, 16'h2222, 16'h0001, 16'hFFFE};
    vecs[5] = '{16'h00FF, 16'hFF01, 16'h8001, 16'h7FFE, 16'h00FF, 16'hFF01};

    model_reset();
    idle(3);
    for (int i = 0; i < 2; i++) begin
      check("rst_gain",   gain[i], 256);
      check("rst_busy",   busy[i], 0);
      check("rst_active", active[i], 0);
      check("rst_out_l",  out_l[i], 0);
      check("rst_valid",  out_valid[i], 0);
    end
    RST_N = 1'b1;
    idle(4);

    // Unity-gain passthrough of the live source, both instances.
    for (int v = 0; v < 6; v++) begin
      send_frame(vecs[v].ll, vecs[v].lr, vecs[v].sl, vecs[v].sr);
      check("pass_valid", out_valid[0], 1);
      for (int i = 0; i < 2; i++) begin
        check("pass_l", out_l[i], vecs[v].el);
        check("pass_r", out_r[i], vecs[v].er);
      end
      idle(1);
    end

    // A 10-cycle glitch on the switch must be ignored.
    SEL_RAW = 1'b1; idle(10); SEL_RAW = 1'b0; idle(30);
    for (int k = 0; k < 3; k++) strobe_chk();
    check("glitch_busy", busy[0], 0);

    // Request synth; not yet accepted 15 cycles in.
    SEL_RAW = 1'b1; idle(14);
    strobe_chk();
    check("early_busy", busy[0], 0);
    idle(20); m_sel = 1'b1;
    strobe_chk();
    check("start_busy", busy[0], 1);
    check("start_gain", gain[0], 256);

    for (int k = 1; k <= 32; k++) begin
      send_rand();
      if (k == 32) begin
        // Strobe landing on the SWAP cycle is emitted silent.
        send_frame(16'sh4000, -16'sh4000, 16'sh3000, -16'sh3000);
        check("swap_frame_valid", out_valid[0], 1);
        check("swap_frame_silent_l", out_l[0], 0);
        check("swap_frame_silent_r", out_r[0], 0);
      end
      idle(3);
      check_status(0); check_status(1);
      check("a_fade_out_gain", gain[0], 256 - 8 * k);
      check("b_ramp_gain", gain[1], b_ramp(k));
    end
    check("a_swapped", active[0], 1);
    check("b_swapped", active[1], 1);
    for (int k = 1; k <= 32; k++) begin
      strobe_chk();
      check("a_fade_in_gain", gain[0], 8 * k);
    end
    check("a_back_to_play", busy[0], 0);

    // Revert mid-fade: back to synth when the ramp reaches 128.
    SEL_RAW = 1'b0; idle(30); m_sel = 1'b0;
    strobe_chk();
    for (int k = 1; k <= 15; k++) strobe_chk();
    check("revert_gain_136", gain[0], 136);
    SEL_RAW = 1'b1; idle(30); m_sel = 1'b1;
    strobe_chk();
    check("revert_gain_128", gain[0], 128);
    check("revert_busy", busy[0], 1);
    send_frame(-16'sd1, -16'sd1, -16'sd1, -16'sd1);
    check("neg_one_at_128", out_l[0], -1);
    idle(3); check_status(0); check_status(1);
    for (int k = 2; k <= 16; k++) begin
      strobe_chk();
      check("revert_climb", gain[0], 128 + 8 * k);
      check("revert_no_swap", active[0], 1);
    end
    check("revert_play", busy[0], 0);
    n = 0;
    while (n < 100 && m_state[1] != PLAY) begin strobe_chk(); n++; end
    check("b_settled", busy[1], 0);

    // Reset in the middle of FADE_IN at gain 64.
    SEL_RAW = 1'b0; idle(30); m_sel = 1'b0;
    strobe_chk();
    for (int k = 1; k <= 40; k++) strobe_chk();
    check("pre_rst_gain", gain[0], 64);
    check("pre_rst_busy", busy[0], 1);
    check("pre_rst_active", active[0], 0);
    #5 RST_N = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("arst_gain",   gain[i], 256);
      check("arst_busy",   busy[i], 0);
      check("arst_active", active[i], 0);
      check("arst_out_l",  out_l[i], 0);
      check("arst_out_r",  out_r[i], 0);
      check("arst_valid",  out_valid[i], 0);
    end
    idle(3);
    model_reset();
    RST_N = 1'b1;
    vcount = 0;
    repeat (20) begin
      @(negedge CLOCK_50);
      if (out_valid[0] || out_valid[1]) vcount++;
    end
    check("no_valid_after_release", vcount, 0);
    check_status(0); check_status(1);

    send_frame(vecs[3].ll, vecs[3].lr, vecs[3].sl, vecs[3].sr);
    check("post_rst_pass", out_l[0], vecs[3].el);
    idle(3);
    check("sb_drained0", sbq[0].size(), 0);
    check("sb_drained1", sbq[1].size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
